keo_dan_xung: RTL and testbench

- Output-side counterpart of the button pulse-shaping stage: converts each rising edge on a clean input into one visible, fixed-width output pulse, e.g. for an LED or for a slow downstream counter input.
- Rising edges that arrive while a pulse is still being produced are queued in a saturating pending counter.
- Queued edges are replayed later as separate pulses, each separated by a guaranteed low gap.

---
 rtl/keo_dan_xung.sv | 118 +++++++++++
 tb/tb_keo_dan_xung.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/keo_dan_xung.sv
// Pulse stretcher: every rising edge on d becomes one ON_CYC-wide high pulse on q,
// followed by at least OFF_CYC low cycles; edges seen while busy are queued and replayed.
module keo_dan_xung #(
  parameter int ON_CYC  = 5000000,
  parameter int OFF_CYC = 5000000,
  parameter int QDEPTH  = 15,
  parameter int CW      = 24
) (
  input  logic       ckht,
  input  logic       rst,
  input  logic       d,
  input  logic       clr,
  output logic       q,
  output logic       busy,
  output logic [3:0] pend,
  output logic       ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);
  localparam logic [3:0]    Q_MAX    = 4'(QDEPTH);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_pend, w_pend_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          r_q, r_busy, r_d_q;
  logic          w_strobe, w_req, w_queue;

  // A strobe coinciding with clr is discarded outright, so only w_req is used below.
  assign w_strobe = d & ~r_d_q;
  assign w_req    = w_strobe & ~clr;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = r_ovf;
    w_queue     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = '0;
        end
      end
      S_ON: begin
        w_queue = 1'b1;
        if (r_cnt == ON_LAST) begin
          w_state_nxt = S_OFF;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_OFF: begin
        if (r_cnt == OFF_LAST) begin
          w_cnt_nxt = '0;
          if ((r_pend != 4'd0 && !clr) || w_req) begin
            // A fresh strobe replaces the consumed queue entry, leaving pend unchanged.
            w_state_nxt = S_ON;
            if (!w_req) w_pend_nxt = r_pend - 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_queue   = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_queue && w_req) begin
      if (r_pend < Q_MAX) w_pend_nxt = r_pend + 4'd1;
      else                w_ovf_nxt  = 1'b1;
    end

    if (clr) begin
      w_pend_nxt = 4'd0;
      w_ovf_nxt  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 4'd0;
      r_ovf   <= 1'b0;
      r_q     <= 1'b0;
      r_busy  <= 1'b0;
      r_d_q   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
      r_q     <= (w_state_nxt == S_ON);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_d_q   <= d;
    end
  end

  assign q    = r_q;
  assign busy = r_busy;
  assign pend = r_pend;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_keo_dan_xung.sv
// Self-checking bench for keo_dan_xung: directed scenarios plus random traffic,
// compared each cycle against a pulse-schedule model built on edge indices.
module tb_keo_dan_xung;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int QD  = 3;
  localparam int CW  = 4;

  logic       ckht = 1'b0;
  logic       rst, d, clr;
  logic       q, busy, ovf;
  logic [3:0] pend;

  keo_dan_xung #(.ON_CYC(ON), .OFF_CYC(OFF), .QDEPTH(QD), .CW(CW)) dut (
    .ckht(ckht), .rst(rst), .d(d), .clr(clr),
    .q(q), .busy(busy), .pend(pend), .ovf(ovf)
  );

  always #5 ckht = ~ckht;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  // Reference model: a pulse is described by the edge index at which q rose;
  // busy lasts ON+OFF edges from there, and edge start+ON+OFF is the decision point.
  int m_edge, m_start, m_pend;
  bit m_active, m_ovf, m_prev_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edge   = 0;
    m_start  = 0;
    m_pend   = 0;
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_prev_d = 1'b1;
  endtask

  task automatic model_edge(input bit di, input bit ci);
    bit req;
    m_edge++;
    req = di && !m_prev_d && !ci;
    m_prev_d = di;
    if (!m_active) begin
      if (req) begin
        m_active = 1'b1;
        m_start  = m_edge;
      end
    end else if (m_edge == m_start + ON + OFF) begin
      if ((m_pend > 0 && !ci) || req) begin
        m_start = m_edge;
        if (!req) m_pend--;
      end else begin
        m_active = 1'b0;
      end
    end else if (req) begin
      if (m_pend < QD) m_pend++;
      else             m_ovf = 1'b1;
    end
    if (ci) begin
      m_pend = 0;
      m_ovf  = 1'b0;
    end
  endtask

  task automatic check_model();
    bit exp_q;
    exp_q = m_active && (m_edge - m_start) < ON;
    check("q",    32'(q),    32'(exp_q));
    check("busy", 32'(busy), 32'(m_active));
    check("pend", 32'(pend), 32'(m_pend));
    check("ovf",  32'(ovf),  32'(m_ovf));
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic step(input bit di, input bit ci = 1'b0);
    logic q_before;
    q_before = q;
    d   = di;
    clr = ci;
    model_edge(di, ci);
    @(posedge ckht);
    #1;
    if (q && !q_before) n_pulses++;
    check_model();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_q",    32'(q),    32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    model_reset();
    @(posedge ckht);
    @(posedge ckht);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int dens;
    rst = 1'b1;
    d   = 1'b1;
    clr = 1'b0;
    #1;
    #1 apply_reset();

    // Level held high through reset release must not request a pulse.
    repeat (10) step(1'b1);
    check("t1_busy", 32'(busy), 32'd0);

    // Single pulse: 3 high, 2 low, idle after the fifth following edge.
    step(1'b0);
    step(1'b1);
    check("t2_q_first", 32'(q), 32'd1);
    repeat (4) step(1'b1);
    check("t2_busy_last", 32'(busy), 32'd1);
    step(1'b1);
    check("t2_idle", 32'(busy), 32'd0);

    // Two queued requests give three pulses in total.
    step(1'b0);
    n_pulses = 0;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    check("t3_pend2", 32'(pend), 32'd2);
    repeat (20) step(1'b0);
    check("t3_pulses", 32'(n_pulses), 32'd3);
    check("t3_pend0",  32'(pend),     32'd0);

    // Dense toggling saturates the queue and sets the sticky overflow.
    n_pulses = 0;
    for (int i = 0; i < 14; i++) step(i % 2 == 0);
    check("t4_pend_sat", 32'(pend), 32'd3);
    repeat (40) step(1'b0);
    check("t4_pulses", 32'(n_pulses), 32'd6);
    check("t4_ovf",    32'(ovf),      32'd1);
    step(1'b0, 1'b1);
    check("t4_ovf_clr", 32'(ovf), 32'd0);

    // Edge in the final OFF cycle restarts immediately, first with pend=0 then pend=2.
    step(1'b1); repeat (4) step(1'b0); step(1'b1);
    check("t5_q_back2back", 32'(q),    32'd1);
    check("t5_pend0",       32'(pend), 32'd0);
    repeat (10) step(1'b0);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    step(1'b0); step(1'b1); step(1'b0); step(1'b0); step(1'b0); step(1'b1);
    check("t5_pend_kept", 32'(pend), 32'd2);
    check("t5_q_restart", 32'(q),    32'd1);
    repeat (20) step(1'b0);

    // Clear during ON: queue and overflow vanish, running pulse finishes, then idle.
    for (int i = 0; i < 13; i++) step(i % 2 == 0);
    check("t6_ovf_set", 32'(ovf), 32'd1);
    step(1'b0, 1'b1);
    check("t6_pend_clr", 32'(pend), 32'd0);
    check("t6_ovf_clr",  32'(ovf),  32'd0);
    step(1'b0); step(1'b0);
    check("t6_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a pulse.
    step(1'b1); step(1'b1);
    check("t6_q_mid", 32'(q), 32'd1);
    #2 apply_reset();

    // Random traffic with varying edge density and occasional clears.
    dens = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) dens = $urandom_range(5, 95);
      step($urandom_range(0, 99) < dens, $urandom_range(0, 59) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
